// File: rtl/mult_stage_array.sv
// mult_stage_array: two-stage lane-parallel weight x pixel multiplier with
// valid/ready back-pressure, per-lane accumulate mode and OUT_WIDTH narrowing.
// Optional build macro MULT_STAGE_SAT_EN: out-of-range results clamp instead
// of wrapping. ovf reports an out-of-range result in either build.
module mult_stage_array #(
  parameter int LANES      = 28,
  parameter int W_WIDTH    = 19,
  parameter int P_WIDTH    = 10,
  parameter int OUT_WIDTH  = 26,
  parameter int FRAC_SHIFT = 3,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           GlobalReset,
  input  logic [LANES*W_WIDTH-1:0]       WeightX,
  input  logic [LANES*P_WIDTH-1:0]       PixelX,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_acc,
  input  logic                           in_last,
  input  logic [LANES-1:0]               lane_en,
  output logic [LANES*OUT_WIDTH-1:0]     Output_syn,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LANES-1:0]               ovf
);

  localparam int PROD_WIDTH = W_WIDTH + P_WIDTH;

  // Stage 1 holding registers
  logic                       s1_valid;
  logic                       s1_acc;
  logic                       s1_last;
  logic [LANES*W_WIDTH-1:0]   s1_w;
  logic [LANES*P_WIDTH-1:0]   s1_p;
  logic [LANES-1:0]           s1_en;

  // Per-lane running sums for accumulate sequences
  logic signed [ACC_WIDTH-1:0] acc [LANES];

  // Per-lane combinational datapath
  logic signed [PROD_WIDTH-1:0] prod   [LANES];
  logic signed [ACC_WIDTH-1:0]  lane_s [LANES];
  logic signed [ACC_WIDTH-1:0]  lane_r [LANES];
  logic [OUT_WIDTH-1:0]         lane_o [LANES];
  logic [LANES-1:0]             lane_ovf;

  logic s2_free;
  logic s1_adv;
  logic in_fire;

  // S2 can take a new beat when empty or when its current output leaves.
  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s1_adv;
  assign in_fire  = in_valid && in_ready;

  // S1 occupancy: refilled or emptied whenever the stage is allowed to move
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (GlobalReset) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // S1 payload capture on an accepted beat
  always_ff @(posedge clk) begin
    // NOTE: payload registers carry no reset; they are only observed while
    // s1_valid is set, so resetting them would only cost routing.
    if (in_fire) begin
      s1_w    <= WeightX;
      s1_p    <= PixelX;
      s1_en   <= lane_en;
      s1_acc  <= in_acc;
      s1_last <= in_acc && in_last;
    end
  end

  // Per-lane multiply, shift, optional accumulate and narrowing
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    prod     = '{default: '0};
    lane_s   = '{default: '0};
    lane_r   = '{default: '0};
    lane_o   = '{default: '0};
    lane_ovf = '0;
    for (int k = 0; k < LANES; k++) begin
      prod[k] = PROD_WIDTH'($signed(s1_w[W_WIDTH*k +: W_WIDTH]))
              * PROD_WIDTH'($signed({1'b0, s1_p[P_WIDTH*k +: P_WIDTH]}));
      lane_s[k] = s1_en[k] ? ACC_WIDTH'(prod[k] >>> FRAC_SHIFT) : '0;
      // In accumulate mode this is the new running sum (non-last beats) or
      // the final dot product (last beat); plain beats bypass acc entirely.
      lane_r[k] = s1_acc ? acc[k] + lane_s[k] : lane_s[k];
      // Fits in OUT_WIDTH signed when all bits above the sign bit match it.
      lane_ovf[k] = !((&lane_r[k][ACC_WIDTH-1:OUT_WIDTH-1]) ||
                      !(|lane_r[k][ACC_WIDTH-1:OUT_WIDTH-1]));
`ifdef MULT_STAGE_SAT_EN
      if (!lane_ovf[k]) begin
        lane_o[k] = lane_r[k][OUT_WIDTH-1:0];
      end else if (lane_r[k][ACC_WIDTH-1]) begin
        lane_o[k] = {1'b1, {(OUT_WIDTH-1){1'b0}}};
      end else begin
        lane_o[k] = {1'b0, {(OUT_WIDTH-1){1'b1}}};
      end
`else
      lane_o[k] = lane_r[k][OUT_WIDTH-1:0];
`endif
    end
  end

  // S2: output register, accumulators and output handshake
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      out_valid  <= 1'b0;
      Output_syn <= '0;
      ovf        <= '0;
      for (int k = 0; k < LANES; k++) begin
        acc[k] <= '0;
      end
    end else if (s2_free) begin
      if (!s1_valid) begin
        out_valid <= 1'b0;
      end else if (s1_acc && !s1_last) begin
        out_valid <= 1'b0;
        for (int k = 0; k < LANES; k++) begin
          acc[k] <= lane_r[k];
        end
      end else begin
        out_valid <= 1'b1;
        ovf       <= lane_ovf;
        for (int k = 0; k < LANES; k++) begin
          Output_syn[OUT_WIDTH*k +: OUT_WIDTH] <= lane_o[k];
          if (s1_acc) begin
            acc[k] <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_stage_array.sv
// Self-checking bench for mult_stage_array: directed scenarios plus random
// beats scored against an arithmetic reference model and expected-output queue.
module tb_mult_stage_array;

  localparam int LANES      = 28;
  localparam int W_WIDTH    = 19;
  localparam int P_WIDTH    = 10;
  localparam int OUT_WIDTH  = 26;
  localparam int FRAC_SHIFT = 3;
  localparam int ACC_WIDTH  = 32;

  logic                       clk = 1'b0;
  logic                       GlobalReset;
  logic [LANES*W_WIDTH-1:0]   WeightX;
  logic [LANES*P_WIDTH-1:0]   PixelX;
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_acc;
  logic                       in_last;
  logic [LANES-1:0]           lane_en;
  logic [LANES*OUT_WIDTH-1:0] Output_syn;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES-1:0]           ovf;

  mult_stage_array dut (
    .clk        (clk),
    .GlobalReset(GlobalReset),
    .WeightX    (WeightX),
    .PixelX     (PixelX),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_acc     (in_acc),
    .in_last    (in_last),
    .lane_en    (lane_en),
    .Output_syn (Output_syn),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LANES*OUT_WIDTH-1:0] out;
    logic [LANES-1:0]           ovf;
  } exp_t;

  exp_t   exp_q[$];
  longint acc_m[LANES];
  int     total = 0;
  int     bad   = 0;
  bit     rand_stall = 1'b0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Two's complement interpretation of a w-bit pattern
  function automatic longint sext(input longint v, input int w);
    longint r;
    r = v & ((64'sd1 <<< w) - 1);
    return (r >= (64'sd1 <<< (w - 1))) ? r - (64'sd1 <<< w) : r;
  endfunction

  function automatic longint floor_div(input longint x, input longint d);
    longint q;
    q = x / d;
    if (x < 0 && (x % d) != 0) q = q - 1;
    return q;
  endfunction

  function automatic longint lane_val(input int k);
    return sext(longint'(Output_syn[k*OUT_WIDTH +: OUT_WIDTH]), OUT_WIDTH);
  endfunction

  // Reference model: applied to the beat currently on the inputs when accepted
  task automatic model_accept();
    exp_t   e;
    longint s, r, v, lo, hi;
    bit     fits;
    lo = -(64'sd1 <<< (OUT_WIDTH - 1));
    hi = (64'sd1 <<< (OUT_WIDTH - 1)) - 1;
    e  = '0;
    for (int k = 0; k < LANES; k++) begin
      s = 0;
      if (lane_en[k])
        s = floor_div(sext(longint'(WeightX[k*W_WIDTH +: W_WIDTH]), W_WIDTH)
                      * longint'(PixelX[k*P_WIDTH +: P_WIDTH]),
                      64'sd1 <<< FRAC_SHIFT);
      if (in_acc && !in_last) begin
        acc_m[k] = sext(acc_m[k] + s, ACC_WIDTH);
      end else begin
        r = in_acc ? sext(acc_m[k] + s, ACC_WIDTH) : s;
        if (in_acc) acc_m[k] = 0;
        fits = (r >= lo) && (r <= hi);
`ifdef MULT_STAGE_SAT_EN
        v = fits ? r : ((r < 0) ? lo : hi);
`else
        v = r;
`endif
        e.out[k*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(v);
        e.ovf[k] = !fits;
      end
    end
    if (!(in_acc && !in_last)) exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_stall) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present one beat and hold it until accepted; reports cycles spent waiting
  task automatic drive(input logic [LANES*W_WIDTH-1:0] w,
                       input logic [LANES*P_WIDTH-1:0] p,
                       input logic [LANES-1:0] en, input logic acc,
                       input logic last, output int stalls);
    stalls   = 0;
    WeightX  = w;
    PixelX   = p;
    lane_en  = en;
    in_acc   = acc;
    in_last  = last;
    in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept();
        tick();
        in_valid = 1'b0;
        return;
      end
      stalls++;
      tick();
    end
    check("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit found);
    found = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        return;
      end
      tick();
    end
    check("out_valid_timeout", 0, 1);
  endtask

  task automatic rand_beat(output logic [LANES*W_WIDTH-1:0] w,
                           output logic [LANES*P_WIDTH-1:0] p);
    for (int k = 0; k < LANES; k++) begin
      w[k*W_WIDTH +: W_WIDTH] = W_WIDTH'($urandom);
      p[k*P_WIDTH +: P_WIDTH] = P_WIDTH'($urandom);
    end
  endtask

  // Output scoreboard and hold-stability monitor
  bit                          stall_seen = 1'b0;
  logic [LANES*OUT_WIDTH-1:0]  held_out;
  logic [LANES-1:0]            held_ovf;
  always @(negedge clk) begin
    exp_t e;
    if (!GlobalReset) begin
      if (stall_seen) begin
        check("hold_valid", out_valid, 1);
        check("hold_data_changed", (Output_syn !== held_out), 0);
        check("hold_ovf", ovf, held_ovf);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          for (int k = 0; k < LANES; k++)
            check($sformatf("lane%0d", k), Output_syn[k*OUT_WIDTH +: OUT_WIDTH],
                  e.out[k*OUT_WIDTH +: OUT_WIDTH]);
          check("ovf", ovf, e.ovf);
        end
      end
    end
    stall_seen = !GlobalReset && out_valid && !out_ready;
    held_out   = Output_syn;
    held_ovf   = ovf;
  end

  initial begin
    logic [LANES*W_WIDTH-1:0] w;
    logic [LANES*P_WIDTH-1:0] p;
    int   stalls;
    bit   found;
    bit   a, l;

    GlobalReset = 1'b1;
    WeightX = '0; PixelX = '0; lane_en = '1;
    in_valid = 1'b0; in_acc = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < LANES; k++) acc_m[k] = 0;
    tick(); tick();
    GlobalReset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_output_zero", (Output_syn != '0), 0);
    check("rst_ovf", ovf, 0);
    tick();

    // Plain beat, lane0 = -3 x 222, two-cycle latency
    rand_beat(w, p);
    w[0 +: W_WIDTH] = 19'h7FFFD;
    p[0 +: P_WIDTH] = 10'd222;
    drive(w, p, '1, 1'b0, 1'b0, stalls);
    @(negedge clk);
    check("latency_cycle1", out_valid, 0);
    tick();
    @(negedge clk);
    check("latency_cycle2", out_valid, 1);
    check("plain_lane0", lane_val(0), -84);
    check("plain_ovf0", ovf[0], 0);
    tick(); tick();

    // Ten back-to-back beats with no stall
    for (int b = 0; b < 10; b++) begin
      rand_beat(w, p);
      drive(w, p, '1, 1'b0, 1'b0, stalls);
      check("b2b_no_stall", stalls, 0);
    end
    repeat (4) tick();
    check("b2b_drained", exp_q.size(), 0);

    // Back-pressure: A then B held while out_ready is low
    out_ready = 1'b0;
    w = '0; p = '0;
    w[0 +: W_WIDTH] = 19'd5; p[0 +: P_WIDTH] = 10'd16;
    drive(w, p, '1, 1'b0, 1'b0, stalls);
    w[0 +: W_WIDTH] = 19'd7; p[0 +: P_WIDTH] = 10'd8;
    drive(w, p, '1, 1'b0, 1'b0, stalls);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_lane0_A", lane_val(0), 10);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_A", lane_val(0), 10);
    tick();
    @(negedge clk);
    check("release_B", lane_val(0), 7);
    tick(); tick();

    // Accumulate two maximal beats into an out-of-range dot product
    w = '0; p = '0;
    w[0 +: W_WIDTH] = 19'd262143; p[0 +: P_WIDTH] = 10'd1023;
    drive(w, p, '1, 1'b1, 1'b0, stalls);
    drive(w, p, '1, 1'b1, 1'b1, stalls);
    wait_out(found);
`ifdef MULT_STAGE_SAT_EN
    check("acc_lane0", lane_val(0), 33554431);
`else
    check("acc_lane0", lane_val(0), -65792);
`endif
    check("acc_ovf0", ovf[0], 1);
    tick();
    repeat (3) tick();
    @(negedge clk);
    check("acc_single_output", out_valid, 0);
    check("acc_queue_empty", exp_q.size(), 0);
    tick();

    // Disabled lane 5 contributes zero; lane 4 unaffected
    rand_beat(w, p);
    w[5*W_WIDTH +: W_WIDTH] = 19'd1000; p[5*P_WIDTH +: P_WIDTH] = 10'd1000;
    w[4*W_WIDTH +: W_WIDTH] = 19'd1000; p[4*P_WIDTH +: P_WIDTH] = 10'd1000;
    drive(w, p, ~(28'd1 << 5), 1'b0, 1'b0, stalls);
    wait_out(found);
    check("lane5_disabled", lane_val(5), 0);
    check("lane4_enabled", lane_val(4), 125000);
    tick(); tick();

    // Reset in the middle of an accumulate sequence
    w = '0; p = '0;
    w[0 +: W_WIDTH] = 19'd100; p[0 +: P_WIDTH] = 10'd100;
    drive(w, p, '1, 1'b1, 1'b0, stalls);
    GlobalReset = 1'b1;
    exp_q.delete();
    for (int k = 0; k < LANES; k++) acc_m[k] = 0;
    tick();
    GlobalReset = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    tick();
    w[0 +: W_WIDTH] = 19'd8; p[0 +: P_WIDTH] = 10'd2;
    drive(w, p, '1, 1'b1, 1'b0, stalls);
    drive(w, p, '1, 1'b1, 1'b0, stalls);
    drive(w, p, '1, 1'b1, 1'b1, stalls);
    wait_out(found);
    check("post_reset_acc", lane_val(0), 6);
    tick(); tick();

    // Random beats with random back-pressure
    rand_stall = 1'b1;
    for (int b = 0; b < 300; b++) begin
      rand_beat(w, p);
      a = ($urandom_range(0, 2) == 0);
      l = ($urandom_range(0, 2) == 0);
      drive(w, p, LANES'($urandom), a, l, stalls);
    end
    rand_stall = 1'b0;
    out_ready  = 1'b1;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) tick();
    tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
